// File: rtl/solitaire_pkg.sv
// rtl/solitaire_pkg.sv - shared pile indices, phase encodings and card field positions
package solitaire_pkg;

    localparam int STOCK_IDX      = 0;
    localparam int FOUNDATION_IDX = 0;
    localparam int NUM_TABLEAU    = 7;

    localparam int CARD_W           = 7;
    localparam int CARD_FACE_UP_BIT = 0;
    localparam int CARD_SUIT_LSB    = 1;
    localparam int CARD_SUIT_MSB    = 2;
    localparam int CARD_RANK_LSB    = 3;
    localparam int CARD_RANK_MSB    = 6;

    typedef enum logic [1:0] {
        PH_SRC = 2'd0,
        PH_OFS = 2'd1,
        PH_DST = 2'd2,
        PH_REQ = 2'd3
    } phase_e;

endpackage

// File: rtl/pile_cursor.sv
// rtl/pile_cursor.sv - modulo-8 pile cursor with left/right wrap and parallel load
module pile_cursor (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       step_left_i,
    input  logic       step_right_i,
    output logic [2:0] pos_o
);

    logic [2:0] pos_q;
    logic [2:0] pos_d;

    // Next position: load wins, otherwise a 3-bit add/subtract gives the 7<->0 wrap for free
    always_comb begin
        pos_d = pos_q;
        if (load_i) begin
            pos_d = load_val_i;
        end else if (step_right_i) begin
            pos_d = pos_q + 3'd1;
        end else if (step_left_i) begin
            pos_d = pos_q - 3'd1;
        end
    end

    // Position register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= 3'd0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/move_request_issuer.sv
// rtl/move_request_issuer.sv - button-driven move command builder with ready/done handshake (optional MOVE_TIMEOUT_EN)
module move_request_issuer #(
    parameter int NUM_TABLEAU    = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_select,
    input  logic        btn_cancel,
    input  logic [27:0] face_up_counts,
    input  logic        move_done,
    input  logic        move_ok,
    output logic        ready,
    output logic [3:0]  source,
    output logic [3:0]  destination,
    output logic [3:0]  source_offset,
    output logic [3:0]  cursor,
    output logic [1:0]  phase,
    output logic        last_ok,
    output logic        err
);

    import solitaire_pkg::*;

    phase_e     phase_q;
    logic [3:0] source_q;
    logic [3:0] destination_q;
    logic [3:0] offset_q;
    logic       ready_q;
    logic       last_ok_q;
    logic       err_q;

    logic       act_cancel;
    logic       act_select;
    logic       act_up;
    logic       act_down;
    logic       act_right;
    logic       act_left;

    logic [2:0] cursor_pos;
    logic [3:0] cursor_w;
    logic [3:0] cursor_cnt;
    logic [3:0] src_cnt;
    logic [3:0] ofs_step;
    logic [3:0] ofs_d;
    logic       cur_load;
    logic       cur_left;
    logic       cur_right;

`ifdef MOVE_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Only the highest-priority pulse acts: cancel > select > up/down > left/right
    always_comb begin
        act_cancel = btn_cancel;
        act_select = btn_select & ~btn_cancel;
        act_up     = btn_up & ~btn_select & ~btn_cancel;
        act_down   = btn_down & ~btn_up & ~btn_select & ~btn_cancel;
        act_right  = btn_right & ~btn_up & ~btn_down & ~btn_select & ~btn_cancel;
        act_left   = btn_left & ~btn_right & ~btn_up & ~btn_down & ~btn_select & ~btn_cancel;
    end

    assign cursor_w = {1'b0, cursor_pos};

    // Live face-up counts for the highlighted pile and the chosen source (stock reads as 0)
    always_comb begin
        cursor_cnt = 4'd0;
        src_cnt    = 4'd0;
        for (int k = 1; k <= NUM_TABLEAU; k++) begin
            if (cursor_w == 4'(k)) begin
                cursor_cnt = face_up_counts[4*k-4 +: 4];
            end
            if (source_q == 4'(k)) begin
                src_cnt = face_up_counts[4*k-4 +: 4];
            end
        end
    end

    // Offset adjust in OFS: saturating up/down, then clamp to the live top face-up card
    always_comb begin
        ofs_step = offset_q;
        if (act_up && (({1'b0, offset_q} + 5'd1) < {1'b0, src_cnt})) begin
            ofs_step = offset_q + 4'd1;
        end else if (act_down && (offset_q != 4'd0)) begin
            ofs_step = offset_q - 4'd1;
        end
        ofs_d = ofs_step;
        if ((src_cnt != 4'd0) && (ofs_step >= src_cnt)) begin
            ofs_d = src_cnt - 4'd1;
        end
    end

    // Cursor moves only while picking piles; completion parks it on the destination
    always_comb begin
        cur_right = act_right & ((phase_q == PH_SRC) | (phase_q == PH_DST));
        cur_left  = act_left & ((phase_q == PH_SRC) | (phase_q == PH_DST));
        cur_load  = (phase_q == PH_REQ) & move_done;
    end

    pile_cursor u_cursor (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_i       (cur_load),
        .load_val_i   (destination_q[2:0]),
        .step_left_i  (cur_left),
        .step_right_i (cur_right),
        .pos_o        (cursor_pos)
    );

    // Selection phase machine with registered command and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_SRC;
            source_q      <= 4'd0;
            destination_q <= 4'd0;
            offset_q      <= 4'd0;
            ready_q       <= 1'b0;
            last_ok_q     <= 1'b0;
            err_q         <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            tmo_q         <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (phase_q)
                PH_SRC: begin
                    if (act_select) begin
                        if (cursor_w == 4'(STOCK_IDX)) begin
                            source_q <= 4'(STOCK_IDX);
                            offset_q <= 4'd0;
                            phase_q  <= PH_DST;
                        end else if (cursor_cnt != 4'd0) begin
                            source_q <= cursor_w;
                            offset_q <= 4'd0;
                            phase_q  <= PH_OFS;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                PH_OFS: begin
                    // An emptied source pile has nothing left to move, so fall back like a cancel
                    if ((src_cnt == 4'd0) || act_cancel) begin
                        phase_q  <= PH_SRC;
                        offset_q <= 4'd0;
                    end else begin
                        offset_q <= ofs_d;
                        if (act_select) begin
                            phase_q <= PH_DST;
                        end
                    end
                end
                PH_DST: begin
                    if (act_cancel) begin
                        phase_q <= PH_SRC;
                    end else if (act_select) begin
                        if ((cursor_w == source_q) && (source_q != 4'(STOCK_IDX))) begin
                            err_q <= 1'b1;
                        end else begin
                            destination_q <= cursor_w;
                            ready_q       <= 1'b1;
                            phase_q       <= PH_REQ;
`ifdef MOVE_TIMEOUT_EN
                            tmo_q         <= '0;
`endif
                        end
                    end
                end
                PH_REQ: begin
                    if (move_done) begin
                        last_ok_q <= move_ok;
                        ready_q   <= 1'b0;
                        phase_q   <= PH_SRC;
`ifdef MOVE_TIMEOUT_EN
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        last_ok_q <= 1'b0;
                        ready_q   <= 1'b0;
                        err_q     <= 1'b1;
                        phase_q   <= PH_SRC;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
`endif
                    end
                end
                default: begin
                    phase_q <= PH_SRC;
                end
            endcase
        end
    end

    assign ready         = ready_q;
    assign source        = source_q;
    assign destination   = destination_q;
    assign source_offset = offset_q;
    assign cursor        = cursor_w;
    assign phase         = phase_q;
    assign last_ok       = last_ok_q;
    assign err           = err_q;

endmodule

// File: tb/tb_move_request_issuer.sv
// tb/tb_move_request_issuer.sv - directed and randomized check of move_request_issuer against a behavioural model
module tb_move_request_issuer;

    localparam int TMO = 8;
`ifdef MOVE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam logic [5:0] B_NONE = 6'b000000;
    localparam logic [5:0] B_C    = 6'b100000;
    localparam logic [5:0] B_S    = 6'b010000;
    localparam logic [5:0] B_U    = 6'b001000;
    localparam logic [5:0] B_D    = 6'b000100;
    localparam logic [5:0] B_R    = 6'b000010;
    localparam logic [5:0] B_L    = 6'b000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_up, btn_down, btn_select, btn_cancel;
    logic [27:0] fuc;
    logic        move_done, move_ok;
    logic        ready, last_ok, err;
    logic [3:0]  source, destination, source_offset, cursor;
    logic [1:0]  phase;

    always #5 clk = ~clk;

    move_request_issuer #(
        .NUM_TABLEAU    (7),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_select     (btn_select),
        .btn_cancel     (btn_cancel),
        .face_up_counts (fuc),
        .move_done      (move_done),
        .move_ok        (move_ok),
        .ready          (ready),
        .source         (source),
        .destination    (destination),
        .source_offset  (source_offset),
        .cursor         (cursor),
        .phase          (phase),
        .last_ok        (last_ok),
        .err            (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: 0=SRC 1=OFS 2=DST 3=REQ
    int m_phase, m_cur, m_src, m_dst, m_ofs, m_ready, m_last_ok, m_err, m_wait;

    function automatic int pile_cnt(input int p);
        logic [27:0] v;
        v = fuc;
        if (p < 1 || p > 7) return 0;
        return int'(v[4*p-4 +: 4]);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic set_cnt(input int p, input int v);
        fuc[4*p-4 +: 4] = 4'(v);
    endtask

    task automatic model_step();
        string act;
        int c;
        if (rst) begin
            m_phase = 0; m_cur = 0; m_src = 0; m_dst = 0; m_ofs = 0;
            m_ready = 0; m_last_ok = 0; m_err = 0; m_wait = 0;
            return;
        end
        m_err = 0;
        if (btn_cancel)      act = "cancel";
        else if (btn_select) act = "select";
        else if (btn_up)     act = "up";
        else if (btn_down)   act = "down";
        else if (btn_right)  act = "right";
        else if (btn_left)   act = "left";
        else                 act = "none";
        case (m_phase)
            0: begin
                if (act == "select") begin
                    if (m_cur == 0) begin
                        m_src = 0; m_ofs = 0; m_phase = 2;
                    end else if (pile_cnt(m_cur) > 0) begin
                        m_src = m_cur; m_ofs = 0; m_phase = 1;
                    end else begin
                        m_err = 1;
                    end
                end else if (act == "right") m_cur = (m_cur + 1) % 8;
                else if (act == "left")      m_cur = (m_cur + 7) % 8;
            end
            1: begin
                c = pile_cnt(m_src);
                if (c == 0 || act == "cancel") begin
                    m_phase = 0; m_ofs = 0;
                end else begin
                    if (act == "up") m_ofs = imin(m_ofs + 1, c - 1);
                    else if (act == "down" && m_ofs > 0) m_ofs = m_ofs - 1;
                    m_ofs = imin(m_ofs, c - 1);
                    if (act == "select") m_phase = 2;
                end
            end
            2: begin
                if (act == "cancel") m_phase = 0;
                else if (act == "select") begin
                    if (m_cur == m_src && m_src != 0) m_err = 1;
                    else begin
                        m_dst = m_cur; m_ready = 1; m_phase = 3; m_wait = 0;
                    end
                end else if (act == "right") m_cur = (m_cur + 1) % 8;
                else if (act == "left")      m_cur = (m_cur + 7) % 8;
            end
            default: begin
                if (move_done) begin
                    m_last_ok = int'(move_ok); m_ready = 0; m_cur = m_dst; m_phase = 0;
                end else if (TMO_EN && m_wait == TMO - 1) begin
                    m_last_ok = 0; m_ready = 0; m_err = 1; m_phase = 0;
                end else begin
                    m_wait++;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("phase", phase, m_phase);
        check("cursor", cursor, m_cur);
        check("source", source, m_src);
        check("destination", destination, m_dst);
        check("source_offset", source_offset, m_ofs);
        check("ready", ready, m_ready);
        check("last_ok", last_ok, m_last_ok);
        check("err", err, m_err);
    endtask

    task automatic do_cycle(input logic r, input logic [5:0] b, input logic d, input logic ok);
        @(negedge clk);
        rst        = r;
        btn_cancel = b[5];
        btn_select = b[4];
        btn_up     = b[3];
        btn_down   = b[2];
        btn_right  = b[1];
        btn_left   = b[0];
        move_done  = d;
        move_ok    = ok;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic press(input logic [5:0] b);
        do_cycle(1'b0, b, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] b;
        rst = 1'b1;
        {btn_cancel, btn_select, btn_up, btn_down, btn_right, btn_left} = '0;
        move_done = 1'b0;
        move_ok   = 1'b0;
        fuc = '0;
        set_cnt(1, 1); set_cnt(2, 0); set_cnt(3, 2); set_cnt(4, 1);
        set_cnt(5, 3); set_cnt(6, 4); set_cnt(7, 0);

        do_cycle(1'b1, B_NONE, 1'b0, 1'b0);
        do_cycle(1'b1, B_NONE, 1'b0, 1'b0);
        check("rst_phase", phase, 0);
        check("rst_ready", ready, 0);

        // Full request: source 3, offset saturates at 1, destination 4
        press(B_R); press(B_R); press(B_R); press(B_S);
        press(B_U); press(B_U); press(B_U); press(B_S);
        press(B_R); press(B_S);
        check("req_source", source, 3);
        check("req_offset", source_offset, 1);
        check("req_dest", destination, 4);
        check("req_ready", ready, 1);
        do_cycle(1'b0, B_NONE, 1'b1, 1'b1);
        check("done_ready", ready, 0);
        check("done_last_ok", last_ok, 1);
        check("done_phase", phase, 0);
        check("done_cursor", cursor, 4);

        // Wrap and stock source skipping OFS
        do_cycle(1'b1, B_NONE, 1'b0, 1'b0);
        press(B_L);
        check("wrap_left", cursor, 7);
        press(B_R);
        check("wrap_right", cursor, 0);
        press(B_S);
        check("stock_phase", phase, 2);
        check("stock_offset", source_offset, 0);
        press(B_C);

        // Rejected selects
        press(B_R); press(B_R); press(B_S);
        check("empty_err", err, 1);
        check("empty_phase", phase, 0);
        press(B_NONE);
        check("err_pulse", err, 0);
        press(B_R); press(B_R); press(B_R); press(B_S); press(B_S); press(B_S);
        check("same_err", err, 1);
        check("same_phase", phase, 2);

        // Cancel beats select in OFS
        press(B_C); press(B_S); press(B_S | B_C);
        check("cancel_wins", phase, 0);

        // Buttons ignored in REQ, then reset in REQ
        press(B_S); press(B_S); press(B_L); press(B_S);
        press(6'b111111); press(B_L); press(B_C); press(B_S | B_R);
        check("req_hold_src", source, 5);
        check("req_hold_dst", destination, 4);
        check("req_hold_phase", phase, 3);
        do_cycle(1'b1, B_NONE, 1'b0, 1'b0);
        check("rst_req_ready", ready, 0);
        check("rst_req_cursor", cursor, 0);
        check("rst_req_src", source, 0);

        // Timeout behaviour (stock -> foundation requests)
        press(B_S); press(B_S);
        do_cycle(1'b0, B_NONE, 1'b1, 1'b1);
        check("pre_tmo_last_ok", last_ok, 1);
        press(B_S); press(B_S);
        for (int i = 0; i < TMO - 1; i++) press(B_NONE);
        check("tmo_still_ready", ready, 1);
        press(B_NONE);
        check("tmo_ready", ready, TMO_EN ? 0 : 1);
        check("tmo_err", err, TMO_EN ? 1 : 0);
        check("tmo_last_ok", last_ok, TMO_EN ? 0 : 1);
        if (!TMO_EN) do_cycle(1'b0, B_NONE, 1'b1, 1'b0);
        press(B_S); press(B_S);
        for (int i = 0; i < TMO - 1; i++) press(B_NONE);
        do_cycle(1'b0, B_NONE, 1'b1, 1'b1);
        check("late_done_ready", ready, 0);
        check("late_done_last_ok", last_ok, 1);
        check("late_done_err", err, 0);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            b = 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63));
            if (b[3] && b[2]) b[2] = 1'b0;
            if (b[1] && b[0]) b[0] = 1'b0;
            if ($urandom_range(0, 9) == 0) set_cnt($urandom_range(1, 7), $urandom_range(0, 4));
            do_cycle(($urandom_range(0, 199) == 0), b,
                     ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
